// File: rtl/pulse_train_generator.sv
// Timed pulse-train driver: n_pulses pulses of on_ticks high / off_ticks low, timed by clk_sl edges sampled on clk_ms.
// First pulse rises 1 clk_ms after accept; start ignored while busy unless PULSE_TRAIN_RETRIGGER_EN is defined.
module pulse_train_generator #(
  parameter int TICK_W  = 8,
  parameter int COUNT_W = 4
) (
  input  logic               clk_ms,
  input  logic               reset,
  input  logic               clk_sl,
  input  logic               start,
  input  logic [TICK_W-1:0]  on_ticks,
  input  logic [TICK_W-1:0]  off_ticks,
  input  logic [COUNT_W-1:0] n_pulses,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] pulse_idx
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0]  on_q, on_d;
  logic [TICK_W-1:0]  off_q, off_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sl_old_q;
`ifdef PULSE_TRAIN_RETRIGGER_EN
  logic               rtrg_q, rtrg_d;
`endif

  logic              tick;
  logic              zero_req;
  logic [TICK_W-1:0] off_eff;
  logic              on_last, off_last, last_pulse;

  assign tick       = clk_sl & ~sl_old_q;
  assign zero_req   = (n_pulses == '0) || (on_ticks == '0);
  // A zero low time still spends one full tick low so pulses stay distinct.
  assign off_eff    = (off_q == '0) ? TICK_W'(1) : off_q;
  assign on_last    = (cnt_q + TICK_W'(1)) == on_q;
  assign off_last   = (cnt_q + TICK_W'(1)) == off_eff;
  assign last_pulse = idx_q == (n_q - COUNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    off_d   = off_q;
    n_d     = n_q;
    idx_d   = idx_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PULSE_TRAIN_RETRIGGER_EN
    rtrg_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          on_d  = on_ticks;
          off_d = off_ticks;
          n_d   = n_pulses;
          if (zero_req) begin
            done_d = 1'b1;
          end else begin
            state_d = ON;
            out_d   = 1'b1;
            busy_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ON: begin
`ifdef PULSE_TRAIN_RETRIGGER_EN
        if (rtrg_q) out_d = 1'b1;
`endif
        if (tick) begin
          if (on_last) begin
            cnt_d = '0;
            out_d = 1'b0;
            if (last_pulse) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = OFF;
            end
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (off_last) begin
            cnt_d   = '0;
            idx_d   = idx_q + COUNT_W'(1);
            state_d = ON;
            out_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PULSE_TRAIN_RETRIGGER_EN
    // Abort and restart; out spends exactly one cycle low before the new first pulse.
    if (start && busy_q) begin
      on_d  = on_ticks;
      off_d = off_ticks;
      n_d   = n_pulses;
      cnt_d = '0;
      idx_d = '0;
      out_d = 1'b0;
      if (zero_req) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ON;
        busy_d  = 1'b1;
        rtrg_d  = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_ms) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      on_q     <= '0;
      off_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sl_old_q <= 1'b0;
`ifdef PULSE_TRAIN_RETRIGGER_EN
      rtrg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      on_q     <= on_d;
      off_q    <= off_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sl_old_q <= clk_sl;
`ifdef PULSE_TRAIN_RETRIGGER_EN
      rtrg_q   <= rtrg_d;
`endif
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_idx = idx_q;

endmodule
